// File: rtl/aes_siso_io.sv
// aes_siso_io
// Byte-serial front/back end for the SISO AES-128 datapath.
// Shifts in 16 key bytes and then 16 plaintext bytes, and presents them to the core as
// 128-bit buses. Once the controller accepts, holds start high for exactly RUN_CYCLES
// cycles. On done, captures the ciphertext and shifts it out MSB byte first.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  input byte handshake; in_data carries the byte
//   key, plaintext     assembled 128-bit buses, first received byte in [127:120]
//   start              to the round controller, high for RUN_CYCLES cycles
//   accept, done, ct   from the controller/core; ct is valid while done=1
//   out_valid/out_ready output byte handshake; out_data is the byte, out_last marks byte 16
//   busy               high in every state except LOAD
//   err                sticky flag: done was missing when the ciphertext was expected
module aes_siso_io #(
    parameter int DATA_W     = 8,
    parameter int BLOCK_W    = 128,
    parameter int RUN_CYCLES = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic [BLOCK_W-1:0] key,
    output logic [BLOCK_W-1:0] plaintext,
    output logic               start,
    input  logic               accept,
    input  logic               done,
    input  logic [BLOCK_W-1:0] ct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_last,
    output logic               busy,
    output logic               err
);

    localparam int BYTES = BLOCK_W / DATA_W;
    localparam int CNT_W = $clog2(2 * BYTES);
    localparam int RUN_W = $clog2(RUN_CYCLES);
    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(2 * BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(BYTES - 1);
    localparam logic [RUN_W-1:0] LAST_RUN = RUN_W'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {
        LOAD,
        ARM,
        RUN,
        CAPTURE,
        SEND
    } state_t;

    state_t                 state_q, state_d;
    logic [2*BLOCK_W-1:0]   shift_q, shift_d;
    logic [BLOCK_W-1:0]     ctReg_q, ctReg_d;
    logic [CNT_W-1:0]       byteCnt_q, byteCnt_d;
    logic [RUN_W-1:0]       runCnt_q, runCnt_d;
    logic                   start_q, start_d;
    logic                   outValid_q, outValid_d;
    logic                   err_q, err_d;

    // State and datapath registers; reset discards any partially loaded or sent block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD;
            shift_q    <= '0;
            ctReg_q    <= '0;
            byteCnt_q  <= '0;
            runCnt_q   <= '0;
            start_q    <= 1'b0;
            outValid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            ctReg_q    <= ctReg_d;
            byteCnt_q  <= byteCnt_d;
            runCnt_q   <= runCnt_d;
            start_q    <= start_d;
            outValid_q <= outValid_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic. The key/plaintext pair is one 256-bit shift register filled at the
    // LSB end, so after 32 bytes the first byte sits at the top of the key. byteCnt is shared
    // between the input phase (0..31) and the output phase (0..15).
    // start is registered: it rises on the ARM->RUN edge and falls on the edge where runCnt
    // reaches RUN_CYCLES-1, giving exactly RUN_CYCLES high cycles. One more high cycle would
    // restart the controller.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        ctReg_d    = ctReg_q;
        byteCnt_d  = byteCnt_q;
        runCnt_d   = runCnt_q;
        start_d    = start_q;
        outValid_d = outValid_q;
        err_d      = err_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    shift_d   = {shift_q[2*BLOCK_W-DATA_W-1:0], in_data};
                    byteCnt_d = byteCnt_q + 1'b1;
                    if (byteCnt_q == LAST_IN) begin
                        byteCnt_d = '0;
                        state_d   = ARM;
                    end
                end
            end
            ARM: begin
                if (accept) begin
                    start_d  = 1'b1;
                    runCnt_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                runCnt_d = runCnt_q + 1'b1;
                if (runCnt_q == LAST_RUN) begin
                    start_d = 1'b0;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                byteCnt_d = '0;
                if (done) begin
                    ctReg_d    = ct;
                    outValid_d = 1'b1;
                    state_d    = SEND;
                end else begin
                    err_d   = 1'b1;
                    state_d = LOAD;
                end
            end
            SEND: begin
                if (out_ready) begin
                    ctReg_d   = {ctReg_q[BLOCK_W-DATA_W-1:0], {DATA_W{1'b0}}};
                    byteCnt_d = byteCnt_q + 1'b1;
                    if (byteCnt_q == LAST_OUT) begin
                        outValid_d = 1'b0;
                        byteCnt_d  = '0;
                        state_d    = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != LOAD);
    assign key       = shift_q[2*BLOCK_W-1 -: BLOCK_W];
    assign plaintext = shift_q[BLOCK_W-1:0];
    assign start     = start_q;
    assign out_valid = outValid_q;
    assign out_data  = ctReg_q[BLOCK_W-1 -: DATA_W];
    assign out_last  = outValid_q && (byteCnt_q == LAST_OUT);
    assign err       = err_q;

endmodule

// File: tb/tb_aes_siso_io.sv
// tb_aes_siso_io
// Directed bench for aes_siso_io. A small round-controller model counts start cycles and
// raises done after the 40th; the ciphertext is supplied directly by the bench.
module tb_aes_siso_io;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ALT_KEY  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] ALT_PT   = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [127:0] ALT_CT   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         start;
    logic         accept;
    logic         done;
    logic [127:0] ct;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         out_last;
    logic         busy;
    logic         err;

    logic [5:0]   ctrlCnt;
    logic         ctrlDone;
    logic         stubDone;
    logic [127:0] ctValue;

    int checks = 0;
    int errors = 0;

    aes_siso_io dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key       (key),
        .plaintext (plaintext),
        .start     (start),
        .accept    (accept),
        .done      (done),
        .ct        (ct),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Round-controller model: each edge with start=1 advances the round count 0x00..0x27;
    // done rises on the 40th such edge and the count returns to zero.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrlCnt  <= '0;
            ctrlDone <= 1'b0;
        end else if (start) begin
            if (ctrlCnt == 6'd39) begin
                ctrlCnt  <= '0;
                ctrlDone <= 1'b1;
            end else begin
                ctrlCnt  <= ctrlCnt + 6'd1;
                ctrlDone <= 1'b0;
            end
        end else begin
            ctrlDone <= 1'b0;
        end
    end

    assign done = ctrlDone & ~stubDone;
    assign ct   = ctValue;

    // Shifts 32 bytes in, optionally with 3-cycle gaps before bytes 8 and 24.
    task automatic loadBlock(input logic [255:0] data, input bit withGaps);
        logic [255:0] sh;
        sh = data;
        for (int i = 0; i < 32; i++) begin
            if (withGaps && (i == 8 || i == 24)) begin
                in_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
            if (i == 31) begin
                checks++;
                if (busy !== 1'b0) begin
                    $display("[TB] FAIL early_arm: busy=%b before byte 32, expected 0", busy);
                    errors++;
                end
            end
            in_valid = 1'b1;
            in_data  = sh[255:248];
            sh       = sh << 8;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Waits for the first output byte and drains all 16, checking order and hold under stall.
    task automatic receiveBlock(input logic [127:0] expCt, input bit stall, input string name);
        int k = 0;
        int cyc = 0;
        int waitCyc = 0;
        logic [127:0] sh;
        sh = expCt;
        while (out_valid !== 1'b1 && waitCyc < 100) begin
            @(negedge clk);
            waitCyc++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            $display("[TB] FAIL %s_out_timeout: out_valid=%b after %0d cycles, expected 1", name, out_valid, waitCyc);
            errors++;
            return;
        end
        while (k < 16 && cyc < 200) begin
            out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            checks++;
            if (out_data !== sh[127:120] || out_last !== (k == 15) || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                $display("[TB] FAIL %s_byte%0d: data=%h last=%b in_ready=%b valid=%b, expected data=%h last=%b in_ready=0 valid=1",
                         name, k, out_data, out_last, in_ready, out_valid, sh[127:120], (k == 15));
                errors++;
            end
            @(negedge clk);
            if (out_ready) begin
                k++;
                sh = sh << 8;
            end
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (k != 16 || out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("[TB] FAIL %s_end: bytes=%0d valid=%b busy=%b, expected 16 0 0", name, k, out_valid, busy);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (key !== '0 || plaintext !== '0 || start !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || err !== 1'b0) begin
            $display("[TB] FAIL reset_regs: key=%h pt=%h start=%b valid=%b last=%b err=%b, expected all 0",
                     key, plaintext, start, out_valid, out_last, err);
            errors++;
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            $display("[TB] FAIL reset_state: busy=%b in_ready=%b, expected 0 1", busy, in_ready);
            errors++;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fips(input string name);
        int lat = 0;
        ctValue = FIPS_CT;
        loadBlock({FIPS_KEY, FIPS_PT}, 1'b0);
        checks++;
        if (key !== FIPS_KEY || plaintext !== FIPS_PT) begin
            $display("[TB] FAIL %s_assembly: key=%h pt=%h, expected %h %h", name, key, plaintext, FIPS_KEY, FIPS_PT);
            errors++;
        end
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 42) begin
            $display("[TB] FAIL %s_latency: got %0d cycles, expected 42", name, lat);
            errors++;
        end
        receiveBlock(FIPS_CT, 1'b0, name);
        checks++;
        if (err !== 1'b0 || key !== FIPS_KEY || plaintext !== FIPS_PT) begin
            $display("[TB] FAIL %s_after: err=%b key=%h pt=%h, expected 0 and unchanged", name, err, key, plaintext);
            errors++;
        end
    endtask

    task automatic test_start_pulse();
        int w = 0;
        int highCnt = 0;
        ctValue = ALT_CT;
        loadBlock({ALT_KEY, ALT_PT}, 1'b0);
        while (start !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        while (start === 1'b1 && highCnt < 100) begin
            highCnt++;
            @(negedge clk);
        end
        checks++;
        if (highCnt != 40 || start !== 1'b0) begin
            $display("[TB] FAIL start_len: high for %0d cycles start=%b, expected 40 then 0", highCnt, start);
            errors++;
        end
        checks++;
        if (done !== 1'b1 || ctrlCnt !== 6'd0) begin
            $display("[TB] FAIL capture_done: done=%b rndNo=%0d, expected 1 0", done, ctrlCnt);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (start !== 1'b0 || ctrlCnt !== 6'd0 || done !== 1'b0 || out_valid !== 1'b1) begin
            $display("[TB] FAIL no_restart: start=%b rndNo=%0d done=%b valid=%b, expected 0 0 0 1",
                     start, ctrlCnt, done, out_valid);
            errors++;
        end
        receiveBlock(ALT_CT, 1'b0, "pulse");
    endtask

    task automatic test_backpressure();
        ctValue = ALT_CT;
        loadBlock({ALT_PT, ALT_KEY}, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hff;
        repeat (20) @(negedge clk);
        checks++;
        if (key !== ALT_PT || plaintext !== ALT_KEY || in_ready !== 1'b0) begin
            $display("[TB] FAIL ignore_in: key=%h pt=%h in_ready=%b, expected %h %h 0", key, plaintext, in_ready, ALT_PT, ALT_KEY);
            errors++;
        end
        in_valid = 1'b0;
        receiveBlock(ALT_CT, 1'b1, "bp");
    endtask

    task automatic test_input_gaps();
        ctValue = FIPS_CT;
        loadBlock({FIPS_KEY, FIPS_PT}, 1'b1);
        checks++;
        if (key !== FIPS_KEY || plaintext !== FIPS_PT || busy !== 1'b1) begin
            $display("[TB] FAIL gap_assembly: key=%h pt=%h busy=%b, expected %h %h 1", key, plaintext, busy, FIPS_KEY, FIPS_PT);
            errors++;
        end
        receiveBlock(FIPS_CT, 1'b0, "gaps");
    endtask

    task automatic test_controller_busy();
        ctValue = FIPS_CT;
        accept  = 1'b0;
        loadBlock({FIPS_KEY, FIPS_PT}, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (start !== 1'b0 || busy !== 1'b1) begin
                $display("[TB] FAIL arm_hold%0d: start=%b busy=%b, expected 0 1", i, start, busy);
                errors++;
            end
            @(negedge clk);
        end
        accept = 1'b1;
        @(negedge clk);
        checks++;
        if (start !== 1'b1) begin
            $display("[TB] FAIL arm_release: start=%b, expected 1", start);
            errors++;
        end
        receiveBlock(FIPS_CT, 1'b0, "busyctrl");
    endtask

    task automatic test_stub_done();
        int w = 0;
        stubDone = 1'b1;
        loadBlock({ALT_KEY, ALT_PT}, 1'b0);
        while (start !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        while (start === 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            $display("[TB] FAIL stub_capture: err=%b busy=%b, expected 0 1", err, busy);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("[TB] FAIL stub_err: err=%b busy=%b in_ready=%b valid=%b, expected 1 0 1 0",
                     err, busy, in_ready, out_valid);
            errors++;
        end
        stubDone = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int w = 0;
        loadBlock({FIPS_PT, FIPS_KEY}, 1'b0);
        while (start !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (20) @(negedge clk);
        checks++;
        if (start !== 1'b1 || err !== 1'b1) begin
            $display("[TB] FAIL pre_abort: start=%b err=%b, expected 1 1", start, err);
            errors++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (start !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0 ||
            key !== '0 || plaintext !== '0 || out_valid !== 1'b0) begin
            $display("[TB] FAIL abort: start=%b busy=%b in_ready=%b err=%b key=%h pt=%h valid=%b, expected 0 0 1 0 0 0 0",
                     start, busy, in_ready, err, key, plaintext, out_valid);
            errors++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        accept    = 1'b1;
        out_ready = 1'b0;
        stubDone  = 1'b0;
        ctValue   = FIPS_CT;
        test_reset();
        test_fips("fips");
        test_start_pulse();
        test_backpressure();
        test_input_gaps();
        test_controller_busy();
        test_stub_done();
        test_reset_mid_run();
        test_fips("after_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
